// File: rtl/ahp_master.sv
// rtl/ahp_master.sv - AHB-Lite burst master: one local command becomes a SINGLE/INCR burst
// Address and data phases are pipelined; address/control only advance on HREADY.
module ahp_master #(
    parameter int MAX_BEATS = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [4:0]  cmd_len,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        done,
    output logic [1:0]  HTRANS,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_INCR8  = 3'b101;
    localparam logic [2:0] BURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LAST
    } state_t;

    state_t      state;
    logic [4:0]  beats_left;
    logic        buf_full;
    logic [31:0] buf_data;
    logic        dp_active;
    logic        dp_write;

    logic [4:0]  len_eff;
    logic [1:0]  size_eff;
    logic [2:0]  burst_sel;
    logic        addr_acc;
    logic        buf_pop;
    logic        buf_push;
    logic        buf_next_full;
    logic [31:0] next_addr;
    logic        crosses;

    always_comb begin
        len_eff = cmd_len;
        if (cmd_len == 5'd0) begin
            len_eff = 5'd1;
        end else if (cmd_len > 5'(MAX_BEATS)) begin
            len_eff = 5'(MAX_BEATS);
        end
        size_eff = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
        case (len_eff)
            5'd1:    burst_sel = BURST_SINGLE;
            5'd4:    burst_sel = BURST_INCR4;
            5'd8:    burst_sel = BURST_INCR8;
            5'd16:   burst_sel = BURST_INCR16;
            default: burst_sel = BURST_INCR;
        endcase
    end

    // A write beat's data leaves the buffer as its address is accepted, so the
    // next word may enter in that same cycle and keep SEQ beats back to back.
    assign addr_acc      = HREADY && HTRANS[1];
    assign buf_pop       = addr_acc && HWRITE;
    assign wdata_ready   = !buf_full || buf_pop;
    assign buf_push      = wdata_valid && wdata_ready;
    assign buf_next_full = buf_push || (buf_full && !buf_pop);
    assign next_addr     = HADDR + (32'd1 << HSIZE);
    assign crosses       = next_addr[31:10] != HADDR[31:10];
    assign cmd_ready     = (state == S_IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= S_IDLE;
            HTRANS      <= TR_IDLE;
            HADDR       <= 32'd0;
            HWRITE      <= 1'b0;
            HSIZE       <= 2'd0;
            HBURST      <= BURST_SINGLE;
            HWDATA      <= 32'd0;
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            beats_left  <= 5'd0;
            buf_full    <= 1'b0;
            buf_data    <= 32'd0;
            dp_active   <= 1'b0;
            dp_write    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            buf_full    <= buf_next_full;
            if (buf_push) begin
                buf_data <= wdata;
            end

            if (HREADY) begin
                if (dp_active && !dp_write) begin
                    rdata       <= HRDATA;
                    rdata_valid <= 1'b1;
                end
                dp_active <= HTRANS[1];
                dp_write  <= HWRITE;
                if (buf_pop) begin
                    HWDATA <= buf_data;
                end
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state      <= S_ADDR;
                        HADDR      <= cmd_addr;
                        HWRITE     <= cmd_write;
                        HSIZE      <= size_eff;
                        HBURST     <= burst_sel;
                        beats_left <= len_eff;
                        HTRANS     <= (!cmd_write || buf_next_full) ? TR_NONSEQ : TR_IDLE;
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        if (HTRANS[1]) begin
                            beats_left <= beats_left - 5'd1;
                            HADDR      <= next_addr;
                            if (beats_left == 5'd1) begin
                                state  <= S_LAST;
                                HTRANS <= TR_IDLE;
                            end else if (crosses) begin
                                // A new 1KB page starts a fresh burst, so its first
                                // beat waits in IDLE rather than BUSY if data is late.
                                HBURST <= BURST_INCR;
                                HTRANS <= (!HWRITE || buf_next_full) ? TR_NONSEQ : TR_IDLE;
                            end else if (HWRITE && !buf_next_full) begin
                                state  <= S_WAIT;
                                HTRANS <= TR_BUSY;
                            end else begin
                                HTRANS <= TR_SEQ;
                            end
                        end else if (!HWRITE || buf_next_full) begin
                            HTRANS <= TR_NONSEQ;
                        end
                    end
                end
                S_WAIT: begin
                    if (HREADY && buf_next_full) begin
                        state  <= S_ADDR;
                        HTRANS <= TR_SEQ;
                    end
                end
                S_LAST: begin
                    if (HREADY) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahp_master.sv
// tb/tb_ahp_master.sv - directed bench for ahp_master with hand-computed bus traces
module tb_ahp_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [4:0]  cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        done;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    int          total = 0;
    int          bad = 0;
    logic [31:0] wq [0:15];
    int          widx;
    int          wn;
    logic        wgate;
    logic        pushed;

    ahp_master #(.MAX_BEATS(16)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_size    (cmd_size),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .done        (done),
        .HTRANS      (HTRANS),
        .HADDR       (HADDR),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: present the write source, note whether it handshakes, move to next negedge.
    task automatic tick();
        wdata       = wq[widx];
        wdata_valid = wgate && (widx < wn);
        #1;
        pushed = wdata_valid && wdata_ready;
        @(negedge HCLK);
        if (pushed) widx++;
    endtask

    task automatic set_cmd(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [4:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_len   = l;
    endtask

    task automatic bus(input string tag, input logic [1:0] tr, input logic [31:0] a);
        chk({tag, "_htrans"}, 32'(HTRANS), 32'(tr));
        chk({tag, "_haddr"}, HADDR, a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_size = 2'd0; cmd_len = 5'd0; wdata_valid = 1'b0; wdata = 32'd0;
        HREADY = 1'b1; HRDATA = 32'd0; wgate = 1'b0; widx = 0; wn = 0; pushed = 1'b0;
        for (int i = 0; i < 16; i++) wq[i] = 32'd0;
        repeat (2) @(negedge HCLK);
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hburst", 32'(HBURST), 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_wdata_ready", 32'(wdata_ready), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rvalid", 32'(rdata_valid), 32'h0);
        HRESETn = 1'b1;
        tick();

        // single write, data arrives a cycle after the command
        wq[0] = 32'hDEADBEEF; widx = 0; wn = 1; wgate = 1'b0;
        set_cmd(1'b1, 32'h10, 2'd2, 5'd1);
        tick();
        cmd_valid = 1'b0;
        chk("w1_nodata_htrans", 32'(HTRANS), 32'h0);
        chk("w1_cmd_ready", 32'(cmd_ready), 32'h0);
        wgate = 1'b1;
        tick();
        bus("w1_beat", 2'b10, 32'h10);
        chk("w1_hburst", 32'(HBURST), 32'h0);
        chk("w1_hwrite", 32'(HWRITE), 32'h1);
        tick();
        chk("w1_last_htrans", 32'(HTRANS), 32'h0);
        chk("w1_hwdata", HWDATA, 32'hDEADBEEF);
        chk("w1_early_done", 32'(done), 32'h0);
        tick();
        chk("w1_done", 32'(done), 32'h1);
        tick();
        chk("w1_done_pulse", 32'(done), 32'h0);
        chk("w1_idle_ready", 32'(cmd_ready), 32'h1);
        wgate = 1'b0;

        // INCR4 read
        set_cmd(1'b0, 32'h20, 2'd2, 5'd4);
        tick();
        cmd_valid = 1'b0;
        bus("r4_b0", 2'b10, 32'h20);
        chk("r4_hburst", 32'(HBURST), 32'h3);
        chk("r4_hwrite", 32'(HWRITE), 32'h0);
        tick();
        bus("r4_b1", 2'b11, 32'h24);
        chk("r4_rvalid0", 32'(rdata_valid), 32'h0);
        HRDATA = 32'hA0; tick();
        bus("r4_b2", 2'b11, 32'h28);
        chk("r4_rv_a0", 32'(rdata_valid), 32'h1);
        chk("r4_rd_a0", rdata, 32'hA0);
        HRDATA = 32'hA1; tick();
        bus("r4_b3", 2'b11, 32'h2C);
        chk("r4_rd_a1", rdata, 32'hA1);
        HRDATA = 32'hA2; tick();
        chk("r4_last_htrans", 32'(HTRANS), 32'h0);
        chk("r4_rd_a2", rdata, 32'hA2);
        chk("r4_early_done", 32'(done), 32'h0);
        HRDATA = 32'hA3; tick();
        chk("r4_rd_a3", rdata, 32'hA3);
        chk("r4_rv_a3", 32'(rdata_valid), 32'h1);
        chk("r4_done", 32'(done), 32'h1);
        tick();
        chk("r4_rv_end", 32'(rdata_valid), 32'h0);

        // INCR4 write with three wait states on the 0x28 beat
        for (int i = 0; i < 4; i++) wq[i] = 32'hC0DE0000 + 32'(i);
        widx = 0; wn = 4; wgate = 1'b1;
        set_cmd(1'b1, 32'h20, 2'd2, 5'd4);
        tick();
        cmd_valid = 1'b0;
        bus("ws_b0", 2'b10, 32'h20);
        chk("ws_hburst", 32'(HBURST), 32'h3);
        tick();
        bus("ws_b1", 2'b11, 32'h24);
        chk("ws_hwdata0", HWDATA, 32'hC0DE0000);
        tick();
        bus("ws_b2", 2'b11, 32'h28);
        chk("ws_hwdata1", HWDATA, 32'hC0DE0001);
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            bus("ws_hold", 2'b11, 32'h28);
            chk("ws_hold_hwdata", HWDATA, 32'hC0DE0001);
        end
        HREADY = 1'b1;
        tick();
        bus("ws_b3", 2'b11, 32'h2C);
        chk("ws_hwdata2", HWDATA, 32'hC0DE0002);
        tick();
        chk("ws_last_htrans", 32'(HTRANS), 32'h0);
        chk("ws_hwdata3", HWDATA, 32'hC0DE0003);
        chk("ws_early_done", 32'(done), 32'h0);
        tick();
        chk("ws_done", 32'(done), 32'h1);
        chk("ws_words_used", 32'(widx), 32'd4);

        // INCR8 write, source starves for two cycles before the fifth beat
        for (int i = 0; i < 8; i++) wq[i] = 32'h50000000 + 32'(i);
        widx = 0; wn = 8; wgate = 1'b1;
        set_cmd(1'b1, 32'h100, 2'd2, 5'd8);
        tick();
        cmd_valid = 1'b0;
        bus("st_b0", 2'b10, 32'h100);
        chk("st_hburst", 32'(HBURST), 32'h5);
        tick(); bus("st_b1", 2'b11, 32'h104); chk("st_hwdata0", HWDATA, 32'h50000000);
        tick(); bus("st_b2", 2'b11, 32'h108); chk("st_hwdata1", HWDATA, 32'h50000001);
        tick(); bus("st_b3", 2'b11, 32'h10C); chk("st_hwdata2", HWDATA, 32'h50000002);
        wgate = 1'b0;
        tick(); bus("st_busy0", 2'b01, 32'h110); chk("st_hwdata3", HWDATA, 32'h50000003);
        tick(); bus("st_busy1", 2'b01, 32'h110);
        wgate = 1'b1;
        tick(); bus("st_b4", 2'b11, 32'h110); chk("st_hwdata3_held", HWDATA, 32'h50000003);
        tick(); bus("st_b5", 2'b11, 32'h114); chk("st_hwdata4", HWDATA, 32'h50000004);
        tick(); bus("st_b6", 2'b11, 32'h118); chk("st_hwdata5", HWDATA, 32'h50000005);
        tick(); bus("st_b7", 2'b11, 32'h11C); chk("st_hwdata6", HWDATA, 32'h50000006);
        tick();
        chk("st_last_htrans", 32'(HTRANS), 32'h0);
        chk("st_hwdata7", HWDATA, 32'h50000007);
        tick();
        chk("st_done", 32'(done), 32'h1);
        chk("st_words_used", 32'(widx), 32'd8);
        wgate = 1'b0;

        // read across the 1KB boundary
        set_cmd(1'b0, 32'h3F8, 2'd2, 5'd4);
        tick();
        cmd_valid = 1'b0;
        bus("kb_b0", 2'b10, 32'h3F8);
        chk("kb_hburst0", 32'(HBURST), 32'h3);
        tick(); bus("kb_b1", 2'b11, 32'h3FC);
        tick(); bus("kb_b2", 2'b10, 32'h400);
        chk("kb_hburst2", 32'(HBURST), 32'h1);
        tick(); bus("kb_b3", 2'b11, 32'h404);
        chk("kb_hburst3", 32'(HBURST), 32'h1);
        tick(); chk("kb_last_htrans", 32'(HTRANS), 32'h0);
        tick(); chk("kb_done", 32'(done), 32'h1);

        // reset during the third beat of a read
        set_cmd(1'b0, 32'h40, 2'd2, 5'd4);
        tick();
        cmd_valid = 1'b0;
        bus("mr_b0", 2'b10, 32'h40);
        tick(); tick();
        bus("mr_b2", 2'b11, 32'h48);
        #2 HRESETn = 1'b0;
        #1;
        bus("mr_rst", 2'b00, 32'h0);
        chk("mr_rst_hburst", 32'(HBURST), 32'h0);
        chk("mr_rst_rvalid", 32'(rdata_valid), 32'h0);
        chk("mr_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("mr_rst_rdata", rdata, 32'h0);
        tick();
        HRESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_no_done", 32'(done), 32'h0);
            chk("mr_idle_htrans", 32'(HTRANS), 32'h0);
        end

        // clean command after reset; size 3 and len 0 are coerced
        wq[0] = 32'h12345678; widx = 0; wn = 1; wgate = 1'b1;
        set_cmd(1'b1, 32'h80, 2'd3, 5'd0);
        tick();
        cmd_valid = 1'b0;
        bus("pr_b0", 2'b10, 32'h80);
        chk("pr_hsize", 32'(HSIZE), 32'h2);
        chk("pr_hburst", 32'(HBURST), 32'h0);
        tick();
        chk("pr_last_htrans", 32'(HTRANS), 32'h0);
        chk("pr_hwdata", HWDATA, 32'h12345678);
        tick();
        chk("pr_done", 32'(done), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
